sysid_read_arbiter: RTL and testbench

Two-master Avalon-MM read arbiter that shares the single read-only system-ID slave (word 0 = ID, word 1 = timestamp) between two requesters, e.g. the Nios II data master and the video-pipeline configuration controller. It serialises requests with round-robin priority, drives the slave address and read strobe, waits a configurable slave read latency, and returns registered data to the granted master with a one-cycle waitrequest release. One transaction is in flight at a time.

---
 rtl/sysid_read_arbiter.sv | 95 +++++++++
 tb/tb_sysid_read_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_read_arbiter.sv
// sysid_read_arbiter: round-robin two-master Avalon-MM read arbiter for the system-ID slave
module sysid_read_arbiter #(
    parameter int DATA_W        = 32,
    parameter int SLAVE_LATENCY = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              m0_read,
    input  logic              m0_address,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic              m1_read,
    input  logic              m1_address,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic              s_address,
    output logic              s_read,
    input  logic [DATA_W-1:0] s_readdata,
    output logic              busy,
    output logic              owner
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              last_q, last_d, owner_q, owner_d, addr_q, addr_d, gnt, cap;
    logic [DATA_W-1:0] m0_data_q, m0_data_d, m1_data_q, m1_data_d;
    // Arbitration, slave latency countdown and capture of the slave word into the owner's data register
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        gnt     = 1'b0;
        cap     = 1'b0;
        case (state_q)
            IDLE: begin
                gnt = (m0_read & m1_read) ? ~last_q : m1_read;
                if (m0_read | m1_read) begin
                    owner_d = gnt;
                    addr_d  = gnt ? m1_address : m0_address;
                    cnt_d   = 2'(SLAVE_LATENCY);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cap     = cnt_q == 2'd0;
                state_d = cap ? RESP : WAIT;
            end
            WAIT: begin
                cnt_d   = cnt_q - 2'd1;
                cap     = cnt_q == 2'd1;
                state_d = cap ? RESP : WAIT;
            end
            default: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
        endcase
        m0_data_d = (cap & ~owner_q) ? s_readdata : m0_data_q;
        m1_data_d = (cap & owner_q) ? s_readdata : m1_data_q;
    end
    // State registers; last starts at 1 so master 0 wins the first tie
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            addr_q    <= 1'b0;
            m0_data_q <= '0;
            m1_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            m0_data_q <= m0_data_d;
            m1_data_q <= m1_data_d;
        end
    end
    assign m0_readdatavalid = (state_q == RESP) & ~owner_q;
    assign m1_readdatavalid = (state_q == RESP) & owner_q;
    assign m0_waitrequest   = ~m0_readdatavalid;
    assign m1_waitrequest   = ~m1_readdatavalid;
    assign m0_readdata      = m0_data_q;
    assign m1_readdata      = m1_data_q;
    assign s_address        = addr_q;
    assign s_read           = (state_q == ISSUE) | (state_q == WAIT);
    assign busy             = state_q != IDLE;
    assign owner            = owner_q;
endmodule

// File: tb/tb_sysid_read_arbiter.sv
// tb_sysid_read_arbiter: directed checks of three arbiter instances with slave latency 0, 2 and 3
module tb_sysid_read_arbiter;
    localparam logic [31:0] K    = 32'd1674984379;
    localparam logic [31:0] JUNK = 32'hBAD0_BAD0;
    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic [2:0]       rst, m0r, m0a, m1r, m1a, w0, v0, w1, v1, sa, sr, bz, ow;
    logic [2:0][31:0] d0, d1, sd;
    int n_chk = 0;
    int n_fail = 0;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int LAT = (g == 0) ? 0 : g + 1;
        logic [2:0] pv, pa;
        always @(posedge clock or posedge rst[g]) begin
            if (rst[g]) begin
                pv <= '0;
                pa <= '0;
            end else begin
                pv <= {pv[1:0], sr[g]};
                pa <= {pa[1:0], sa[g]};
            end
        end
        if (LAT == 0) begin : g_comb
            assign sd[g] = sa[g] ? K : 32'd0;
        end else begin : g_pipe
            assign sd[g] = pv[LAT-1] ? (pa[LAT-1] ? K : 32'd0) : JUNK;
        end
        sysid_read_arbiter #(.DATA_W(32), .SLAVE_LATENCY(LAT)) u_dut (
            .clock            (clock),
            .reset            (rst[g]),
            .m0_read          (m0r[g]),
            .m0_address       (m0a[g]),
            .m0_waitrequest   (w0[g]),
            .m0_readdata      (d0[g]),
            .m0_readdatavalid (v0[g]),
            .m1_read          (m1r[g]),
            .m1_address       (m1a[g]),
            .m1_waitrequest   (w1[g]),
            .m1_readdata      (d1[g]),
            .m1_readdatavalid (v1[g]),
            .s_address        (sa[g]),
            .s_read           (sr[g]),
            .s_readdata       (sd[g]),
            .busy             (bz[g]),
            .owner            (ow[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input int i, input string tag);
        chk({tag, "_w0"}, w0[i], 1);
        chk({tag, "_w1"}, w1[i], 1);
        chk({tag, "_v0"}, v0[i], 0);
        chk({tag, "_v1"}, v1[i], 0);
        chk({tag, "_d0"}, d0[i], 0);
        chk({tag, "_d1"}, d1[i], 0);
        chk({tag, "_sread"}, sr[i], 0);
        chk({tag, "_saddr"}, sa[i], 0);
        chk({tag, "_busy"}, bz[i], 0);
        chk({tag, "_owner"}, ow[i], 0);
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int got, c0, c1, n, ns;
        bit seen;
        rst = 3'b111; m0r = 0; m0a = 0; m1r = 0; m1a = 0;
        tick(); tick();
        for (int i = 0; i < 3; i++) chk_reset(i, "reset");
        rst = 0;
        tick();
        // single master, combinational slave
        m0r[0] = 1; m0a[0] = 1;
        tick();
        chk("t1_busy", bz[0], 1);
        chk("t1_sread", sr[0], 1);
        chk("t1_saddr", sa[0], 1);
        chk("t1_no_early_valid", v0[0], 0);
        chk("t1_wait_held", w0[0], 1);
        tick();
        chk("t1_valid", v0[0], 1);
        chk("t1_wait_low", w0[0], 0);
        chk("t1_data", d0[0], K);
        chk("t1_m1_wait", w1[0], 1);
        chk("t1_m1_valid", v1[0], 0);
        chk("t1_sread_resp", sr[0], 0);
        chk("t1_owner", ow[0], 0);
        m0r[0] = 0;
        tick();
        chk("t1_valid_end", v0[0], 0);
        chk("t1_idle", bz[0], 0);
        chk("t1_wait_back", w0[0], 1);
        chk("t1_data_hold", d0[0], K);
        chk("t1_m1_data", d1[0], 0);
        // tie after reset
        rst[0] = 1;
        tick();
        rst[0] = 0;
        m0r[0] = 1; m0a[0] = 0; m1r[0] = 1; m1a[0] = 1;
        tick();
        chk("tie_owner0", ow[0], 0);
        chk("tie_saddr0", sa[0], 0);
        tick();
        chk("tie_v0", v0[0], 1);
        chk("tie_d0", d0[0], 0);
        chk("tie_v1_low", v1[0], 0);
        chk("tie_w1_high", w1[0], 1);
        m0r[0] = 0;
        tick();
        chk("tie_gap_idle", bz[0], 0);
        chk("tie_gap_w1", w1[0], 1);
        tick();
        chk("tie_owner1", ow[0], 1);
        chk("tie_saddr1", sa[0], 1);
        chk("tie_w1_issue", w1[0], 1);
        tick();
        chk("tie_v1", v1[0], 1);
        chk("tie_w1_low", w1[0], 0);
        chk("tie_d1", d1[0], K);
        chk("tie_v0_low", v0[0], 0);
        m1r[0] = 0;
        tick();
        // round-robin fairness
        m0r[0] = 1; m1r[0] = 1; m0a[0] = 1; m1a[0] = 0;
        got = 0; c0 = 0; c1 = 0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            tick();
            if (v0[0] | v1[0]) begin
                chk("rr_one_strobe", v0[0] & v1[0], 0);
                chk("rr_order", v1[0], got % 2);
                chk("rr_data", v1[0] ? d1[0] : d0[0], v1[0] ? 32'd0 : K);
                c0 += int'(v0[0]);
                c1 += int'(v1[0]);
                got++;
            end
        end
        m0r[0] = 0; m1r[0] = 0;
        chk("rr_total", got, 8);
        chk("rr_count_m0", c0, 4);
        chk("rr_count_m1", c1, 4);
        tick();
        chk("rr_idle", bz[0], 0);
        // slave latency 3
        m1r[2] = 1; m1a[2] = 1;
        n = 0; ns = 0; seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            n++;
            if (sr[2]) ns++;
            if (v1[2]) seen = 1;
        end
        chk("l3_seen", seen, 1);
        chk("l3_latency", n, 5);
        chk("l3_sread_cycles", ns, 4);
        chk("l3_data", d1[2], K);
        chk("l3_m0_idle", v0[2], 0);
        m1r[2] = 0;
        tick();
        chk("l3_idle", bz[2], 0);
        // reset during WAIT, slave latency 2
        m0r[1] = 1; m0a[1] = 1;
        tick(); tick();
        chk("l2_wait_sread", sr[1], 1);
        chk("l2_wait_busy", bz[1], 1);
        #2 rst[1] = 1;
        #1 chk_reset(1, "async_reset");
        m0r[1] = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("reset_no_valid", v0[1], 0);
        end
        rst[1] = 0;
        m1r[1] = 1; m1a[1] = 1;
        n = 0; seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            n++;
            chk("l2_no_m0_valid", v0[1], 0);
            if (v1[1]) seen = 1;
        end
        chk("l2_seen", seen, 1);
        chk("l2_latency", n, 4);
        chk("l2_data", d1[1], K);
        m1r[1] = 0;
        tick();
        chk("l2_idle", bz[1], 0);
        // early read drop
        m0r[0] = 1; m0a[0] = 0;
        tick();
        chk("drop_busy", bz[0], 1);
        chk("drop_owner", ow[0], 0);
        m0r[0] = 0;
        tick();
        chk("drop_valid", v0[0], 1);
        chk("drop_data", d0[0], 0);
        tick();
        chk("drop_valid_once", v0[0], 0);
        chk("drop_idle", bz[0], 0);
        chk("drop_wait", w0[0], 1);
        tick();
        chk("drop_stays_idle", bz[0], 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
